// File: rtl/inst_rom_ctrl_pkg.sv
// Shared definitions for the instruction ROM controller: bus widths, the
// default NOP instruction and the program-loader state encoding.
package inst_rom_ctrl_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_DATA_BUS = 32;

  // addi x0, x0, 0
  localparam logic [INST_DATA_BUS-1:0] NOP_INST = 32'h0000_0013;

  localparam int LOAD_STATE_W = 3;

  typedef enum logic [LOAD_STATE_W-1:0] {
    LS_IDLE   = 3'd0,
    LS_LEN    = 3'd1,
    LS_DATA   = 3'd2,
    LS_FINISH = 3'd3,
    LS_ABORT  = 3'd4
  } load_state_e;

endpackage

// File: rtl/inst_rom_ctrl_rom_mem.sv
// Instruction word array: asynchronous read port for fetch, synchronous
// write port for the program loader. Contents are never reset.
module inst_rom_ctrl_rom_mem #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Loader writes land on the clock edge that carries the last byte of a word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_ctrl.sv
// Instruction-memory responder with an in-system program loader.
//
// Fetch: ins_o answers pc_i combinationally. Out-of-range addresses and any
// access while the loader is active return NOP_INST.
//
// Loader byte interface: rx_valid_i is a one-cycle strobe qualifying
// rx_data_i; there is no back-pressure, every strobed byte is consumed in the
// cycle it is presented (strobes in IDLE, FINISH and ABORT are dropped).
// Stream: 4-byte little-endian word count N, then N little-endian words
// written from word index 0 upward.
module inst_rom_ctrl #(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          ADDR_W      = 12,
  parameter int          TIMEOUT_CYC = 1000000,
  parameter logic [31:0] NOP_INST    = inst_rom_ctrl_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  output logic [31:0] ins_o,
  input  logic        load_req_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        cpu_hold_o,
  output logic        load_busy_o,
  output logic        load_done_o,
  output logic        load_err_o,
  output logic [2:0]  dbg_state
);

  import inst_rom_ctrl_pkg::*;

  localparam int WCNT_W = ADDR_W + 1;
  localparam int TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  load_state_e       state, state_n;
  logic [1:0]        byte_cnt;
  logic [WCNT_W-1:0] word_cnt;
  logic [WCNT_W-1:0] n_words_q;
  logic [23:0]       len_q;
  logic [23:0]       word_buf;
  logic [TMO_W-1:0]  tmo_cnt;

  logic [31:0]       len_full;
  logic [31:0]       word_full;
  logic              last_byte;
  logic              last_word;
  logic              tmo_hit;
  logic              mem_we;
  logic [31:0]       mem_rdata;
  logic              out_of_range;
  logic              unused_pc_lsb;

  // The 4th byte completes the value in the same cycle it arrives.
  assign len_full  = {rx_data_i, len_q};
  assign word_full = {rx_data_i, word_buf};
  assign last_byte = rx_valid_i && (byte_cnt == 2'd3);
  assign last_word = ((word_cnt + WCNT_W'(1)) == n_words_q);
  // Abort once the idle count is about to reach TIMEOUT_CYC-1.
  assign tmo_hit   = !rx_valid_i &&
                     ((32'(tmo_cnt) + 32'd1) == 32'(TIMEOUT_CYC - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LS_IDLE;
    else        state <= state_n;
  end

  // Next-state logic and memory write strobe.
  always_comb begin
    state_n = state;
    mem_we  = 1'b0;
    case (state)
      LS_IDLE: begin
        if (load_req_i) state_n = LS_LEN;
      end
      LS_LEN: begin
        if (last_byte) begin
          if (len_full == 32'd0)                   state_n = LS_FINISH;
          else if (len_full > 32'(DEPTH_WORDS))    state_n = LS_ABORT;
          else                                     state_n = LS_DATA;
        end else if (tmo_hit) begin
          state_n = LS_ABORT;
        end
      end
      LS_DATA: begin
        if (last_byte) begin
          mem_we = 1'b1;
          if (last_word) state_n = LS_FINISH;
        end else if (tmo_hit) begin
          state_n = LS_ABORT;
        end
      end
      LS_FINISH: state_n = LS_IDLE;
      LS_ABORT:  state_n = LS_IDLE;
      default:   state_n = LS_IDLE;
    endcase
  end

  // Byte packer, word counter and saturating idle-timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt  <= '0;
      word_cnt  <= '0;
      n_words_q <= '0;
      len_q     <= '0;
      word_buf  <= '0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        LS_IDLE: begin
          if (load_req_i) begin
            byte_cnt  <= '0;
            word_cnt  <= '0;
            n_words_q <= '0;
            len_q     <= '0;
            tmo_cnt   <= '0;
          end
        end
        LS_LEN, LS_DATA: begin
          if (rx_valid_i) begin
            byte_cnt <= byte_cnt + 2'd1;
            tmo_cnt  <= '0;
            if (state == LS_LEN) begin
              case (byte_cnt)
                2'd0:    len_q[7:0]   <= rx_data_i;
                2'd1:    len_q[15:8]  <= rx_data_i;
                2'd2:    len_q[23:16] <= rx_data_i;
                default: n_words_q    <= len_full[WCNT_W-1:0];
              endcase
            end else begin
              case (byte_cnt)
                2'd0:    word_buf[7:0]   <= rx_data_i;
                2'd1:    word_buf[15:8]  <= rx_data_i;
                2'd2:    word_buf[23:16] <= rx_data_i;
                default: word_cnt        <= word_cnt + WCNT_W'(1);
              endcase
            end
          end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  inst_rom_ctrl_rom_mem #(
    .DEPTH (DEPTH_WORDS),
    .AW    (ADDR_W),
    .DW    (32)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (word_cnt[ADDR_W-1:0]),
    .wdata (word_full),
    .raddr (pc_i[ADDR_W+1:2]),
    .rdata (mem_rdata)
  );

  // Byte offset within a word is irrelevant to a word-aligned fetch.
  assign unused_pc_lsb = ^pc_i[1:0];
  assign out_of_range  = |pc_i[31:ADDR_W+2];

  assign load_busy_o = (state != LS_IDLE);
  assign cpu_hold_o  = load_busy_o;
  assign load_done_o = (state == LS_FINISH);
  assign load_err_o  = (state == LS_ABORT);
  assign dbg_state   = state;

  assign ins_o = (load_busy_o || out_of_range) ? NOP_INST : mem_rdata;

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// Bench for inst_rom_ctrl: loads programs through the byte loader and
// checks the fetch path against a word-array model of the program image.
module tb_inst_rom_ctrl;

  localparam int          DEPTH   = 4096;
  localparam int          TMO     = 16;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] ins_o;
  logic        load_req_i = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        cpu_hold_o, load_busy_o, load_done_o, load_err_o;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  int err_seen = 0;
  int nop_bad = 0;
  int hold_bad = 0;

  logic [31:0] ref_mem [DEPTH];
  bit          ref_known [DEPTH];

  inst_rom_ctrl #(
    .DEPTH_WORDS (DEPTH),
    .ADDR_W      (12),
    .TIMEOUT_CYC (TMO),
    .NOP_INST    (NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_i        (pc_i),
    .ins_o       (ins_o),
    .load_req_i  (load_req_i),
    .rx_valid_i  (rx_valid_i),
    .rx_data_i   (rx_data_i),
    .cpu_hold_o  (cpu_hold_o),
    .load_busy_o (load_busy_o),
    .load_done_o (load_done_o),
    .load_err_o  (load_err_o),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse counters and always-true properties, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (load_done_o) done_seen++;
      if (load_err_o)  err_seen++;
      if (load_busy_o && ins_o !== NOP) nop_bad++;
      if (load_busy_o !== cpu_hold_o)   hold_bad++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    pc_i       = 32'($urandom_range(0, 32'h3FFF));
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
    rx_data_i  = 8'($urandom);
  endtask

  task automatic start_load();
    load_req_i = 1'b1;
    tick();
    load_req_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int b = 0; b < 4; b++) begin
      repeat ($urandom_range(0, max_gap)) tick();
      send_byte(w[8*b +: 8]);
    end
  endtask

  // Full load; returns positioned in the cycle after the last byte.
  task automatic run_program(input logic [31:0] prog[$], input int max_gap);
    start_load();
    send_word(32'(prog.size()), max_gap);
    foreach (prog[i]) send_word(prog[i], max_gap);
  endtask

  task automatic model_write(input logic [31:0] prog[$]);
    foreach (prog[i]) begin
      ref_mem[i]   = prog[i];
      ref_known[i] = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    if (load_busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", load_busy_o); end
    checks++;
    if (cpu_hold_o !== 1'b0) begin failures++; $display("FAIL reset_hold: got %b want 0", cpu_hold_o); end
    checks++;
    rst_n = 1'b1;
    tick();
    if (load_done_o !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", load_done_o); end
    checks++;
    if (load_err_o !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", load_err_o); end
    checks++;
  endtask

  task automatic test_basic_load();
    logic [7:0] bytes [12] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00,
                               8'h13, 8'h01, 8'h50, 8'h00};
    int d0 = done_seen;
    int e0 = err_seen;
    start_load();
    if (cpu_hold_o !== 1'b1 || load_busy_o !== 1'b1) begin
      failures++; $display("FAIL basic_hold_start: got hold=%b busy=%b want 1/1", cpu_hold_o, load_busy_o);
    end
    checks++;
    foreach (bytes[i]) send_byte(bytes[i]);
    if (load_done_o !== 1'b1 || cpu_hold_o !== 1'b1) begin
      failures++; $display("FAIL basic_finish: got done=%b hold=%b want 1/1", load_done_o, cpu_hold_o);
    end
    checks++;
    tick();
    if (load_done_o !== 1'b0 || cpu_hold_o !== 1'b0) begin
      failures++; $display("FAIL basic_idle: got done=%b hold=%b want 0/0", load_done_o, cpu_hold_o);
    end
    checks++;
    ref_mem[0] = 32'h00A0_0093; ref_known[0] = 1'b1;
    ref_mem[1] = 32'h0050_0113; ref_known[1] = 1'b1;
    pc_i = 32'h0; #1;
    if (ins_o !== 32'h00A0_0093) begin failures++; $display("FAIL basic_mem0: got %h want 00a00093", ins_o); end
    checks++;
    pc_i = 32'h4; #1;
    if (ins_o !== 32'h0050_0113) begin failures++; $display("FAIL basic_mem1: got %h want 00500113", ins_o); end
    checks++;
    if (done_seen - d0 != 1 || err_seen != e0) begin
      failures++; $display("FAIL basic_pulses: got done=%0d err=%0d want 1/0", done_seen - d0, err_seen - e0);
    end
    checks++;
  endtask

  task automatic test_read_path();
    logic [31:0] prog[$];
    for (int i = 0; i < 4; i++) prog.push_back($urandom);
    prog[3] = 32'h00A0_0093;
    run_program(prog, 2);
    if (load_done_o !== 1'b1) begin failures++; $display("FAIL read_load_done: got %b want 1", load_done_o); end
    checks++;
    tick();
    model_write(prog);
    pc_i = 32'h0000_000C; #1;
    if (ins_o !== 32'h00A0_0093) begin failures++; $display("FAIL read_pc0c: got %h want 00a00093", ins_o); end
    checks++;
    pc_i = 32'h0000_000E; #1;
    if (ins_o !== 32'h00A0_0093) begin failures++; $display("FAIL read_lsb_ignored: got %h want 00a00093", ins_o); end
    checks++;
    pc_i = 32'h0001_0000; #1;
    if (ins_o !== NOP) begin failures++; $display("FAIL read_oor_10000: got %h want %h", ins_o, NOP); end
    checks++;
    pc_i = 32'h0000_4000; #1;
    if (ins_o !== NOP) begin failures++; $display("FAIL read_oor_4000: got %h want %h", ins_o, NOP); end
    checks++;
  endtask

  task automatic test_random_loads();
    for (int r = 0; r < 4; r++) begin
      logic [31:0] prog[$];
      int n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) prog.push_back($urandom);
      run_program(prog, 4);
      if (load_done_o !== 1'b1) begin failures++; $display("FAIL rand_done[%0d]: got %b want 1", r, load_done_o); end
      checks++;
      tick();
      model_write(prog);
      for (int k = 0; k < 8; k++) begin
        int idx = $urandom_range(0, 15);
        if (ref_known[idx]) begin
          pc_i = {18'h0, 12'(idx), 2'($urandom)}; #1;
          if (ins_o !== ref_mem[idx]) begin
            failures++; $display("FAIL rand_read[%0d]: got %h want %h", idx, ins_o, ref_mem[idx]);
          end
          checks++;
        end
        pc_i = {18'($urandom_range(1, 32'h3FFFF)), 14'($urandom)}; #1;
        if (ins_o !== NOP) begin failures++; $display("FAIL rand_oor pc=%h: got %h want %h", pc_i, ins_o, NOP); end
        checks++;
      end
    end
  endtask

  task automatic test_oversize();
    int d0 = done_seen;
    int e0 = err_seen;
    start_load();
    send_word(32'd4097, 0);
    if (load_err_o !== 1'b1 || cpu_hold_o !== 1'b1) begin
      failures++; $display("FAIL oversize_abort: got err=%b hold=%b want 1/1", load_err_o, cpu_hold_o);
    end
    checks++;
    tick();
    if (load_err_o !== 1'b0 || load_busy_o !== 1'b0) begin
      failures++; $display("FAIL oversize_idle: got err=%b busy=%b want 0/0", load_err_o, load_busy_o);
    end
    checks++;
    pc_i = 32'h0; #1;
    if (ins_o !== ref_mem[0]) begin failures++; $display("FAIL oversize_mem0: got %h want %h", ins_o, ref_mem[0]); end
    checks++;
    if (err_seen - e0 != 1 || done_seen != d0) begin
      failures++; $display("FAIL oversize_pulses: got err=%0d done=%0d want 1/0", err_seen - e0, done_seen - d0);
    end
    checks++;
  endtask

  // N equal to the array depth is legal: loader must enter DATA, then time out.
  task automatic test_depth_boundary();
    int k = 0;
    start_load();
    send_word(32'(DEPTH), 0);
    if (load_err_o !== 1'b0 || load_busy_o !== 1'b1) begin
      failures++; $display("FAIL depth_accept: got err=%b busy=%b want 0/1", load_err_o, load_busy_o);
    end
    checks++;
    for (int c = 1; c <= 100; c++) begin
      if (load_err_o === 1'b1) begin k = c; break; end
      tick();
    end
    if (k != TMO) begin failures++; $display("FAIL depth_timeout_cycle: got %0d want %0d", k, TMO); end
    checks++;
    tick();
  endtask

  task automatic test_timeout();
    int k = 0;
    int e0 = err_seen;
    start_load();
    send_word(32'd1, 0);
    send_byte(8'hAA);
    send_byte(8'h55);
    for (int c = 1; c <= 100; c++) begin
      if (load_err_o === 1'b1) begin k = c; break; end
      tick();
    end
    if (k != TMO) begin failures++; $display("FAIL timeout_cycle: got %0d want %0d", k, TMO); end
    checks++;
    tick();
    if (load_busy_o !== 1'b0) begin failures++; $display("FAIL timeout_idle: got busy=%b want 0", load_busy_o); end
    checks++;
    pc_i = 32'h0; #1;
    if (ins_o !== ref_mem[0]) begin failures++; $display("FAIL timeout_mem0: got %h want %h", ins_o, ref_mem[0]); end
    checks++;
    if (err_seen - e0 != 1) begin failures++; $display("FAIL timeout_pulses: got %0d want 1", err_seen - e0); end
    checks++;
  endtask

  task automatic test_reset_mid_data();
    logic [31:0] w0 = $urandom;
    logic [31:0] w1 = $urandom;
    logic [31:0] prog[$];
    int d0 = done_seen;
    int e0 = err_seen;
    start_load();
    send_word(32'd2, 1);
    send_word(w0, 1);
    send_byte(w1[7:0]);
    rst_n = 1'b0;
    #1;
    if (load_busy_o !== 1'b0 || cpu_hold_o !== 1'b0 || load_done_o !== 1'b0 || load_err_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: got busy=%b hold=%b done=%b err=%b want 0000",
               load_busy_o, cpu_hold_o, load_done_o, load_err_o);
    end
    checks++;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    if (done_seen != d0 || err_seen != e0) begin
      failures++; $display("FAIL rst_no_pulse: got done=%0d err=%0d want 0/0", done_seen - d0, err_seen - e0);
    end
    checks++;
    ref_mem[0] = w0; ref_known[0] = 1'b1;
    pc_i = 32'h0; #1;
    if (ins_o !== w0) begin failures++; $display("FAIL rst_partial_kept: got %h want %h", ins_o, w0); end
    checks++;
    prog.push_back($urandom);
    prog.push_back($urandom);
    run_program(prog, 2);
    if (load_done_o !== 1'b1) begin failures++; $display("FAIL rst_reload_done: got %b want 1", load_done_o); end
    checks++;
    tick();
    model_write(prog);
    pc_i = 32'h4; #1;
    if (ins_o !== ref_mem[1]) begin failures++; $display("FAIL rst_reload_mem1: got %h want %h", ins_o, ref_mem[1]); end
    checks++;
  endtask

  task automatic test_zero_len_and_ignore();
    int d0;
    repeat (3) send_byte(8'($urandom));
    if (load_busy_o !== 1'b0) begin failures++; $display("FAIL idle_rx_ignored: got busy=%b want 0", load_busy_o); end
    checks++;
    d0 = done_seen;
    start_load();
    send_byte(8'h00);
    load_req_i = 1'b1;
    tick();
    load_req_i = 1'b0;
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    if (load_done_o !== 1'b1) begin failures++; $display("FAIL zero_len_done: got %b want 1", load_done_o); end
    checks++;
    load_req_i = 1'b1;
    send_byte(8'h5A);
    load_req_i = 1'b0;
    if (load_busy_o !== 1'b0 || load_done_o !== 1'b0) begin
      failures++; $display("FAIL finish_ignores: got busy=%b done=%b want 0/0", load_busy_o, load_done_o);
    end
    checks++;
    if (done_seen - d0 != 1) begin failures++; $display("FAIL zero_len_pulses: got %0d want 1", done_seen - d0); end
    checks++;
    pc_i = 32'h0; #1;
    if (ins_o !== ref_mem[0]) begin failures++; $display("FAIL zero_len_mem0: got %h want %h", ins_o, ref_mem[0]); end
    checks++;
  endtask

  task automatic test_global_props();
    if (nop_bad != 0) begin failures++; $display("FAIL nop_while_busy: got %0d bad cycles want 0", nop_bad); end
    checks++;
    if (hold_bad != 0) begin failures++; $display("FAIL hold_eq_busy: got %0d bad cycles want 0", hold_bad); end
    checks++;
  endtask

  initial begin
    foreach (ref_known[i]) ref_known[i] = 1'b0;
    test_reset();
    test_basic_load();
    test_read_path();
    test_random_loads();
    test_oversize();
    test_depth_boundary();
    test_timeout();
    test_reset_mid_data();
    test_zero_len_and_ignore();
    test_global_props();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
